// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus load/store initiator:
// funct3 codes, FSM state encoding and access decode helpers.
package periph_bus_pkg;

   localparam int unsigned READ_LATENCY_DEF = 1;
   localparam int unsigned DATA_W           = 32;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Loads accept 0,1,2,4,5; stores accept 0,1,2.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      if (we) return (f3 > 3'd2);
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   // Access size lives in funct3[1:0]: 0 byte, 1 half, 2 word.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
      case (f3[1:0])
         2'd1:    return lane[0];
         2'd2:    return (lane != 2'd0);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// Word-addressed peripheral bus: address, write strobe, write data and
// one-cycle registered read data from the responder.
interface periph_bus_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_wr;
   logic [31:0]       bus_wdata;
   logic [31:0]       bus_rdata;

   modport master (output bus_addr, output bus_wr, output bus_wdata, input bus_rdata);
   modport slave  (input bus_addr, input bus_wr, input bus_wdata, output bus_rdata);
endinterface

// File: rtl/periph_bus_master_lsu_align.sv
// Combinational lane handling: load extract/extend and sub-word store
// merge into a previously read word.
module lsu_align
   import periph_bus_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   input  logic [15:0] wdata,
   output logic [31:0] load_data_c,
   output logic [31:0] merged_c
);

   logic [4:0]  sh;
   logic [15:0] shifted;
   logic [31:0] mask;

   assign sh      = {lane, 3'b000};
   assign shifted = 16'(rdata >> sh);

   always_comb begin
      load_data_c = 32'd0;
      case (funct3)
         F3_LB:   load_data_c = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   load_data_c = {{16{shifted[15]}}, shifted[15:0]};
         F3_LW:   load_data_c = rdata;
         F3_LBU:  load_data_c = {24'd0, shifted[7:0]};
         F3_LHU:  load_data_c = {16'd0, shifted[15:0]};
         default: load_data_c = 32'd0;
      endcase
   end

   always_comb begin
      mask     = 32'd0;
      merged_c = rdata;
      case (funct3)
         F3_SB: begin
            mask     = 32'h0000_00FF << sh;
            merged_c = (rdata & ~mask) | (32'(wdata[7:0]) << sh);
         end
         F3_SH: begin
            mask     = 32'h0000_FFFF << sh;
            merged_c = (rdata & ~mask) | (32'(wdata) << sh);
         end
         default: merged_c = rdata;
      endcase
   end

endmodule

// File: rtl/periph_bus_master.sv
// Single-outstanding load/store initiator for the word-addressed peripheral
// bus, with read-modify-write for byte/halfword stores.
module periph_bus_master
   import periph_bus_pkg::*;
#(
   parameter int unsigned READ_LATENCY = READ_LATENCY_DEF,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   periph_bus_if.master      bus
);

   localparam int unsigned CNT_W = $clog2(READ_LATENCY + 2);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        lane_q, lane_d;
   logic [2:0]        f3_q, f3_d;
   logic              we_q, we_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic              bus_wr_q, bus_wr_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic              req_bad_c;
   logic [31:0]       load_data_c;
   logic [31:0]       merged_c;

   lsu_align u_align (
      .funct3      (f3_q),
      .lane        (lane_q),
      .rdata       (bus.bus_rdata),
      .wdata       (wdata_q),
      .load_data_c (load_data_c),
      .merged_c    (merged_c)
   );

   assign req_bad_c = f3_illegal(req_we, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
   assign req_ready = rst & (state_q == ST_IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lane_d      = lane_q;
      f3_d        = f3_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      bus_addr_d  = bus_addr_q;
      bus_wr_d    = 1'b0;
      bus_wdata_d = bus_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               lane_d     = req_addr[1:0];
               f3_d       = req_funct3;
               we_d       = req_we;
               wdata_d    = req_wdata[15:0];
               bus_addr_d = {2'b00, req_addr[ADDR_W-1:2]};
               if (req_bad_c) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'd0;
               end else if (req_we && (req_funct3 == F3_SW)) begin
                  state_d     = ST_WRITE;
                  bus_wr_d    = 1'b1;
                  bus_wdata_d = req_wdata;
               end else begin
                  state_d = ST_READ;
                  cnt_d   = '0;
               end
            end
         end
         // Read data is captured on the last edge of the READ window.
         ST_READ: begin
            if (cnt_q == CNT_W'(READ_LATENCY)) begin
               if (we_q) begin
                  state_d     = ST_WRITE;
                  bus_wr_d    = 1'b1;
                  bus_wdata_d = merged_c;
               end else begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
                  rsp_rdata_d = load_data_c;
               end
            end else begin
               cnt_d = CNT_W'(cnt_q + 1'b1);
            end
         end
         ST_WRITE: begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'd0;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         lane_q      <= 2'd0;
         f3_q        <= 3'd0;
         we_q        <= 1'b0;
         wdata_q     <= 16'd0;
         bus_addr_q  <= '0;
         bus_wr_q    <= 1'b0;
         bus_wdata_q <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lane_q      <= lane_d;
         f3_q        <= f3_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         bus_addr_q  <= bus_addr_d;
         bus_wr_q    <= bus_wr_d;
         bus_wdata_q <= bus_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wr    = bus_wr_q;
   assign bus.bus_wdata = bus_wdata_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master: vector table of single requests
// plus hand-written reset-abort and back-to-back sequences.
module tb_periph_bus_master;
   import periph_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic        pre_en;
   logic [1:0]  pre_idx;
   logic [31:0] pre_val;
   logic [31:0] mem [4];

   int checks = 0;
   int errors = 0;

   periph_bus_if #(.ADDR_W(32)) bus ();

   periph_bus_master #(.READ_LATENCY(1), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Responder: four words, registered read data, preload port for setup.
   always @(posedge clk) begin
      if (pre_en) mem[pre_idx] <= pre_val;
      else if (bus.bus_wr) mem[bus.bus_addr[1:0]] <= bus.bus_wdata;
      bus.bus_rdata <= mem[bus.bus_addr[1:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [1:0] idx, input logic [31:0] val);
      @(negedge clk);
      pre_en = 1'b1; pre_idx = idx; pre_val = val;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic rdy, output int lat,
                          output logic [31:0] rdata, output logic err, output int wr_cnt,
                          output logic [31:0] wa, output logic [31:0] wd, output logic extra);
      @(negedge clk);
      rdy = req_ready;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = -1; wr_cnt = 0; rdata = 32'hX; err = 1'bx; wa = 32'd0; wd = 32'd0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (bus.bus_wr) begin
            wr_cnt++;
            wa = bus.bus_addr;
            wd = bus.bus_wdata;
         end
         if (rsp_valid) begin
            lat = k; rdata = rsp_rdata; err = rsp_err;
            break;
         end
      end
      @(negedge clk);
      extra = rsp_valid | bus.bus_wr;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wr;
      logic [31:0] exp_wa;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic        rdy, err, extra;
      int          lat, wr_cnt;
      logic [31:0] rdata, wa, wd;
      int          n_acc, n_rsp, n_wr, rsp1_c;
      int          acc_c [2];
      logic [31:0] wr_a [4];
      logic [31:0] wr_d [4];
      logic        saw_rsp;

      vecs[0]  = '{1'b0, F3_LW,  32'h0, 32'h0,        32'h12345680, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[1]  = '{1'b0, F3_LB,  32'h0, 32'h0,        32'hFFFFFF80, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[2]  = '{1'b0, F3_LBU, 32'h0, 32'h0,        32'h00000080, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[3]  = '{1'b0, F3_LHU, 32'h2, 32'h0,        32'h00001234, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[4]  = '{1'b0, F3_LB,  32'h1, 32'h0,        32'h00000056, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[5]  = '{1'b1, F3_SB,  32'h5, 32'h000000AB, 32'h0,        1'b0, 4, 1, 32'h1, 32'h1122AB44};
      vecs[6]  = '{1'b0, F3_LW,  32'h4, 32'h0,        32'h1122AB44, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[7]  = '{1'b0, F3_LH,  32'h3, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0, 32'h0};
      vecs[8]  = '{1'b1, F3_SW,  32'h2, 32'h55555555, 32'h0,        1'b1, 1, 0, 32'h0, 32'h0};
      vecs[9]  = '{1'b0, 3'd3,   32'h0, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0, 32'h0};
      vecs[10] = '{1'b1, 3'd4,   32'h0, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0, 32'h0};
      vecs[11] = '{1'b1, F3_SW,  32'h4, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'h1, 32'hDEADBEEF};
      vecs[12] = '{1'b0, F3_LH,  32'h6, 32'h0,        32'hFFFFDEAD, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[13] = '{1'b0, F3_LB,  32'h7, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[14] = '{1'b1, F3_SH,  32'h2, 32'h1234CAFE, 32'h0,        1'b0, 4, 1, 32'h0, 32'hCAFE5680};
      vecs[15] = '{1'b0, F3_LHU, 32'h2, 32'h0,        32'h0000CAFE, 1'b0, 3, 0, 32'h0, 32'h0};
      vecs[16] = '{1'b0, F3_LH,  32'h0, 32'h0,        32'h00005680, 1'b0, 3, 0, 32'h0, 32'h0};

      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      pre_en = 1'b0; pre_idx = 2'd0; pre_val = 32'd0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset req_ready", 32'(req_ready), 32'd0);
      chk("reset bus_wr", 32'(bus.bus_wr), 32'd0);
      chk("reset bus_addr", bus.bus_addr, 32'd0);
      chk("reset bus_wdata", bus.bus_wdata, 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b1;

      preload(2'd0, 32'h12345680);
      preload(2'd1, 32'h11223344);
      preload(2'd2, 32'h0);
      preload(2'd3, 32'h0);

      foreach (vecs[i]) begin
         run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                 rdy, lat, rdata, err, wr_cnt, wa, wd, extra);
         chk($sformatf("v%0d req_ready", i), 32'(rdy), 32'd1);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("v%0d rsp_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("v%0d rsp_err", i), 32'(err), 32'(vecs[i].exp_err));
         chk($sformatf("v%0d bus_wr count", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
         chk($sformatf("v%0d trailing activity", i), 32'(extra), 32'd0);
         if (vecs[i].exp_wr != 0) begin
            chk($sformatf("v%0d bus_addr", i), wa, vecs[i].exp_wa);
            chk($sformatf("v%0d bus_wdata", i), wd, vecs[i].exp_wd);
         end
      end

      // Reset during the READ of a load aborts it silently
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      saw_rsp = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         saw_rsp = saw_rsp | rsp_valid;
         chk("abort req_ready in reset", 32'(req_ready), 32'd0);
         chk("abort bus_wr in reset", 32'(bus.bus_wr), 32'd0);
      end
      rst = 1'b1;
      #1 chk("abort req_ready after release", 32'(req_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         saw_rsp = saw_rsp | rsp_valid;
      end
      chk("abort no rsp_valid", 32'(saw_rsp), 32'd0);
      run_req(1'b0, F3_LW, 32'h0, 32'h0, rdy, lat, rdata, err, wr_cnt, wa, wd, extra);
      chk("post-abort LW latency", 32'(lat), 32'd3);
      chk("post-abort LW rdata", rdata, 32'hCAFE5680);
      chk("post-abort LW err", 32'(err), 32'd0);

      // Two SWs with req_valid held high
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW;
      req_addr = 32'h8; req_wdata = 32'hA5A5A5A5;
      n_acc = 0; n_rsp = 0; n_wr = 0; rsp1_c = -1; acc_c[0] = -1; acc_c[1] = -1;
      for (int c = 0; c < 16; c++) begin
         logic acc_now;
         if (bus.bus_wr && n_wr < 4) begin
            wr_a[n_wr] = bus.bus_addr;
            wr_d[n_wr] = bus.bus_wdata;
            n_wr++;
         end
         if (rsp_valid) begin
            n_rsp++;
            if (n_rsp == 1) rsp1_c = c;
         end
         acc_now = req_ready & req_valid;
         if (acc_now && n_acc < 2) acc_c[n_acc] = c;
         @(posedge clk);
         #1;
         if (acc_now) begin
            n_acc++;
            if (n_acc == 1) begin
               req_addr = 32'hC; req_wdata = 32'h5A5A5A5A;
            end else begin
               req_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      chk("b2b accept count", 32'(n_acc), 32'd2);
      chk("b2b first rsp cycle", 32'(rsp1_c), 32'd2);
      chk("b2b second accept after rsp", 32'(acc_c[1]), 32'(rsp1_c + 1));
      chk("b2b rsp count", 32'(n_rsp), 32'd2);
      chk("b2b bus_wr count", 32'(n_wr), 32'd2);
      if (n_wr >= 2) begin
         chk("b2b wr0 addr", wr_a[0], 32'h2);
         chk("b2b wr0 data", wr_d[0], 32'hA5A5A5A5);
         chk("b2b wr1 addr", wr_a[1], 32'h3);
         chk("b2b wr1 data", wr_d[1], 32'h5A5A5A5A);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
Load/store initiator for the word-addressed peripheral bus (addr/wr/idata/odata, one-cycle registered read data). It takes one core memory request at a time and converts the byte address to a word index. It issues the bus read and/or write, performs read-modify-write for SB/SH, and aligns and extends load data. It sits between the core's memory stage and the peripheral register block.

Parameters:
READ_LATENCY, 1, cycles from bus_addr valid to bus_rdata valid (responder registers read data once)
ADDR_W, 32, width of req_addr and bus_addr

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets)
req_valid  in  1  core request present
req_ready  out  1  request accepted when req_valid & req_ready at clk edge
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (low bits used for SB/SH)
rsp_valid  out  1  one-cycle pulse: request complete
rsp_rdata  out  32  load result, 0 for stores/errors
rsp_err  out  1  misaligned or illegal funct3, qualified by rsp_valid
bus_addr  out  ADDR_W  word index = {2'b0, addr[ADDR_W-1:2]}
bus_wr  out  1  write strobe to responder
bus_wdata  out  32  write data
bus_rdata  in  32  read data from responder

Behaviour:
- Reset (rst==0 at edge): state IDLE; bus_addr=0, bus_wr=0, bus_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready = rst & (state==IDLE), so it is 0 while in reset.
- All outputs except req_ready are registered.
- Reset mid-operation aborts the transaction. bus_wr is 0 after the edge, and no rsp_valid is produced for the aborted request.
- States are IDLE, READ, WRITE, RESP. There is no backpressure on the response.
- IDLE (req_ready=1): on acceptance, latch addr, funct3, we and wdata, then decode:
  - Illegal funct3: loads 3, 6, 7; stores >2.
  - Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned: go to RESP with err=1 and no bus activity.
  - SW: go to WRITE, with bus_wdata=req_wdata.
  - Any load, SB, SH: go to READ.
  - bus_addr is loaded with the word index on acceptance.
- READ: bus_wr=0. Lasts exactly READ_LATENCY+1 cycles (counter). bus_rdata is sampled on the final cycle's edge.
  - Loads: extract lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend. Go to RESP.
  - SB/SH: merge store bytes into the sampled word at lane addr[1:0] → bus_wdata, then go to WRITE.
- WRITE: bus_wr=1 for exactly one cycle, then RESP. At most one write cycle per request.
- RESP: rsp_valid=1 for one cycle, with rsp_rdata/rsp_err valid. Next state IDLE; rsp_valid is cleared on the following edge.
- Timing for READ_LATENCY=1, with acceptance at edge E0 and cycle k = k-th cycle after E0:
  - SW: rsp in cycle 2.
  - Load: rsp in cycle 3.
  - SB/SH: write in cycle 3, rsp in cycle 4.
  - Error: rsp in cycle 1.
- bus_addr and bus_wdata hold their last values outside transactions. bus_wr is 0 in every state but WRITE.
- A new request is accepted no earlier than the cycle after RESP (i.e. when IDLE is re-entered).

Decomposition:
- Shared package periph_bus_pkg: funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2), state encoding, default READ_LATENCY.
- One sub-module, lsu_align (combinational): load lane extract/extend and store byte-merge, driven by funct3 and addr[1:0].

Test Plan:
1. SW addr 0x4, wdata 0xDEADBEEF → cycle 1: bus_addr=1, bus_wr=1, bus_wdata=0xDEADBEEF; bus_wr=1 only that cycle; cycle 2: rsp_valid=1, err=0, rdata=0.
2. Responder word0=0x12345680:
   - LW 0x0 → rdata 0x12345680.
   - LB 0x0 → 0xFFFFFF80.
   - LBU 0x0 → 0x00000080.
   - LHU 0x2 → 0x00001234.
   - Each gives rsp_valid in cycle 3, and bus_wr stays 0.
3. Responder word1=0x11223344; SB addr 0x5, wdata 0x000000AB → one bus_wr with bus_addr=1, bus_wdata=0x1122AB44; read back word1 = 0x1122AB44.
4. LH addr 0x3 and SW addr 0x2 → rsp_valid in cycle 1, err=1, rdata=0, no bus_wr.
5. rst driven 0 during READ of an LW → no rsp_valid, bus_wr=0, req_ready=0 during reset; after release, req_ready=1 and the next LW completes normally.
6. req_valid held high with two queued SWs → second accepted only after rsp_valid of first; exactly two bus_wr pulses, one per request, in order.
